// File: rtl/axi4_read_arbiter_2to1_pkg.sv
// Shared encodings for the two-source AXI4 read arbiter: FSM states,
// burst type constants and read response codes.
package axi4_read_arbiter_2to1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_read_arbiter_2to1_rr_arbiter_2.sv
// Two-way round-robin pick: a lone requester wins outright; on a tie the
// source that did not win last time is chosen.
module rr_arbiter_2 (
  input  logic [1:0] request,
  input  logic       last_grant,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    if (request == 2'b11) begin
      winner = ~last_grant;
    end else begin
      winner = request[1];
    end
  end

endmodule

// File: rtl/axi4_read_arbiter_2to1.sv
// Merges two AXI4 read masters onto one downstream read master, one burst
// in flight at a time, round-robin between the sources.
module axi4_read_arbiter_2to1
  import axi4_read_arbiter_2to1_pkg::*;
#(
  parameter int C_ADDRESS_WIDTH  = 32,
  parameter int C_DATA_WIDTH     = 32,
  parameter int C_RESET_PRIORITY = 0
) (
  input  logic                       CLK,
  input  logic                       RES,
  input  logic [C_ADDRESS_WIDTH-1:0] S0_ARADDR,
  input  logic [7:0]                 S0_ARLEN,
  input  logic [2:0]                 S0_ARSIZE,
  input  logic [1:0]                 S0_ARBURST,
  input  logic                       S0_ARVALID,
  output logic                       S0_ARREADY,
  output logic [C_DATA_WIDTH-1:0]    S0_RDATA,
  output logic [1:0]                 S0_RRESP,
  output logic                       S0_RLAST,
  output logic                       S0_RVALID,
  input  logic                       S0_RREADY,
  input  logic [C_ADDRESS_WIDTH-1:0] S1_ARADDR,
  input  logic [7:0]                 S1_ARLEN,
  input  logic [2:0]                 S1_ARSIZE,
  input  logic [1:0]                 S1_ARBURST,
  input  logic                       S1_ARVALID,
  output logic                       S1_ARREADY,
  output logic [C_DATA_WIDTH-1:0]    S1_RDATA,
  output logic [1:0]                 S1_RRESP,
  output logic                       S1_RLAST,
  output logic                       S1_RVALID,
  input  logic                       S1_RREADY,
  output logic [C_ADDRESS_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                 M_AXI_ARLEN,
  output logic [2:0]                 M_AXI_ARSIZE,
  output logic [1:0]                 M_AXI_ARBURST,
  output logic                       M_AXI_ARVALID,
  input  logic                       M_AXI_ARREADY,
  input  logic [C_DATA_WIDTH-1:0]    M_AXI_RDATA,
  input  logic [1:0]                 M_AXI_RRESP,
  input  logic                       M_AXI_RLAST,
  input  logic                       M_AXI_RVALID,
  output logic                       M_AXI_RREADY,
  output logic [1:0]                 dbg_state_o
);

  // Handshakes: a transfer occurs on a rising CLK edge where VALID and READY
  // are both high; VALID never waits on READY, and the payload is held
  // stable while VALID is high and READY is low.

  localparam logic RST_LAST_GRANT = (C_RESET_PRIORITY == 0) ? 1'b1 : 1'b0;

  state_e                     state_q, state_d;
  logic                       grant_q, grant_d;
  logic                       last_grant_q, last_grant_d;
  logic [C_ADDRESS_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]                 arlen_q, arlen_d;
  logic [2:0]                 arsize_q, arsize_d;
  logic [1:0]                 arburst_q, arburst_d;
  logic                       winner;
  logic                       r_last_hs;

  rr_arbiter_2 u_rr (
    .request    ({S1_ARVALID, S0_ARVALID}),
    .last_grant (last_grant_q),
    .winner     (winner)
  );

  assign r_last_hs = M_AXI_RVALID & M_AXI_RREADY & M_AXI_RLAST;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= RST_LAST_GRANT;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arburst_d    = arburst_q;
    case (state_q)
      ST_IDLE: begin
        if (S0_ARVALID || S1_ARVALID) begin
          grant_d   = winner;
          araddr_d  = winner ? S1_ARADDR  : S0_ARADDR;
          arlen_d   = winner ? S1_ARLEN   : S0_ARLEN;
          arsize_d  = winner ? S1_ARSIZE  : S0_ARSIZE;
          arburst_d = winner ? S1_ARBURST : S0_ARBURST;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // Fairness history only advances once the burst is actually accepted.
        if (M_AXI_ARREADY) begin
          last_grant_d = grant_q;
          state_d      = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_last_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = arlen_q;
  assign M_AXI_ARSIZE  = arsize_q;
  assign M_AXI_ARBURST = arburst_q;
  assign M_AXI_ARVALID = (state_q == ST_ADDR);

  assign S0_ARREADY = (state_q == ST_ADDR) && !grant_q && M_AXI_ARREADY;
  assign S1_ARREADY = (state_q == ST_ADDR) &&  grant_q && M_AXI_ARREADY;

  // R payload is broadcast; only the granted source ever sees RVALID.
  assign S0_RDATA  = M_AXI_RDATA;
  assign S1_RDATA  = M_AXI_RDATA;
  assign S0_RRESP  = M_AXI_RRESP;
  assign S1_RRESP  = M_AXI_RRESP;
  assign S0_RLAST  = M_AXI_RLAST;
  assign S1_RLAST  = M_AXI_RLAST;
  assign S0_RVALID = (state_q == ST_DATA) && !grant_q && M_AXI_RVALID;
  assign S1_RVALID = (state_q == ST_DATA) &&  grant_q && M_AXI_RVALID;

  assign M_AXI_RREADY = (state_q == ST_DATA) && (grant_q ? S1_RREADY : S0_RREADY);

  assign dbg_state_o = state_q;

endmodule

// File: doc/axi4_read_arbiter_2to1.md
Name:
axi4_read_arbiter_2to1

Overview:
- Merges two AXI4 read-only master ports (S0 = instruction cache, S1 = data cache, each a readonly_cache AXI master) onto one AXI4 read master toward the memory interconnect.
- Sits directly downstream of each cache's AXI read port.
- One burst outstanding at a time. Round-robin arbitration. The R channel is routed to the granted source.

Parameters:
- C_ADDRESS_WIDTH, 32, address width on all ports.
- C_DATA_WIDTH, 32, data width on all ports.
- C_RESET_PRIORITY, 0, source preferred on the first simultaneous request after reset (0 = S0, 1 = S1).

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RES  in  1  asynchronous, active-high reset.
- S0_ARADDR, S1_ARADDR  in  C_ADDRESS_WIDTH each  burst start address.
- S0_ARLEN, S1_ARLEN  in  8 each  beats minus 1.
- S0_ARSIZE/ARBURST, S1_ARSIZE/ARBURST  in  3/2 each  passed through to master.
- S0_ARVALID, S1_ARVALID  in  1 each  request valid.
- S0_ARREADY, S1_ARREADY  out  1 each  request accepted.
- S0_RDATA, S1_RDATA  out  C_DATA_WIDTH each  read data (broadcast).
- S0_RRESP, S1_RRESP  out  2 each  response (broadcast).
- S0_RLAST, S1_RLAST  out  1 each  last beat (broadcast).
- S0_RVALID, S1_RVALID  out  1 each  beat valid, granted source only.
- S0_RREADY, S1_RREADY  in  1 each  beat accept.
- M_AXI_ARADDR/ARLEN/ARSIZE/ARBURST  out  C_ADDRESS_WIDTH/8/3/2  registered copy of winner's request.
- M_AXI_ARVALID  out  1;  M_AXI_ARREADY  in  1.
- M_AXI_RDATA/RRESP/RLAST/RVALID  in  C_DATA_WIDTH/2/1/1.
- M_AXI_RREADY  out  1.

Behaviour:
- Reset (RES high, asynchronous):
  - state = IDLE.
  - last_grant = ~C_RESET_PRIORITY.
  - M_AXI_ARVALID = 0; M_AXI_AR* fields = 0.
  - S*_ARREADY = 0, S*_RVALID = 0, M_AXI_RREADY = 0.
  - Reset mid-burst abandons the downstream burst; memory side is reset together.
- IDLE:
  - If any S*_ARVALID: winner = the single requester, or ~last_grant when both request.
  - Latch winner's ARADDR/LEN/SIZE/BURST into M_AXI_AR*, set M_AXI_ARVALID = 1, grant = winner, go to ADDR.
  - Latency: S*_ARVALID at cycle N gives M_AXI_ARVALID at N+1.
- ADDR:
  - M_AXI_AR* held stable.
  - S[grant]_ARREADY = M_AXI_ARREADY (combinational); other ARREADY = 0.
  - On M_AXI_ARREADY: M_AXI_ARVALID <= 0, last_grant <= grant, go to DATA.
- DATA:
  - S[grant]_RVALID = M_AXI_RVALID; M_AXI_RREADY = S[grant]_RREADY; non-granted RVALID = 0.
  - RDATA/RRESP/RLAST broadcast to both sources.
  - On M_AXI_RVALID & M_AXI_RREADY & M_AXI_RLAST: go to IDLE.
- M_AXI_RREADY = 0 outside DATA; stray R beats stall and are not consumed.
- Non-granted source's ARVALID stays pending. It is never dropped and its ARREADY stays 0.
- Requests of a source that deasserts ARVALID early (protocol violation) are still completed once latched.
- RRESP is passed unmodified and has no effect on the FSM. No beat counting: RLAST alone terminates.
- Turnaround: last beat handshake at cycle N; next M_AXI_ARVALID at N+2 (one IDLE cycle).
- Fairness: both sources continuously requesting produce grants S0, S1, S0, S1…

Decomposition:
- Shared package: state encoding (IDLE/ADDR/DATA), AXI burst constants (INCR = 2'b01), RRESP codes.
- One sub-module: rr_arbiter_2. Inputs: request[1:0], last_grant. Output: winner.

Test Plan:
- Single request: reset, S0 ARADDR=0x1000 ARLEN=3; ARREADY after 2 cycles; 4 beats returned.
  - M_AXI_ARVALID rises 1 cycle after S0_ARVALID.
  - S0 receives 4 beats, S0_RLAST on the 4th.
  - S1_RVALID never 1.
- Simultaneous requests: S0=0x1000 and S1=0x2000 in the same cycle after reset.
  - S0 burst issued first, then S1.
  - Next simultaneous pair grants S0 again.
- R backpressure: S1_RREADY low 3 cycles during beat 2 of an S1 ARLEN=7 burst.
  - M_AXI_RREADY low for exactly those cycles.
  - All 8 beats arrive in order, none lost.
- Request during a burst: S1 requests while an S0 burst is in DATA.
  - S1_ARREADY stays 0 until S0 RLAST handshake at cycle N.
  - M_AXI_ARADDR=S1 address with ARVALID at N+2.
- Async reset mid-DATA: RES asserted.
  - All valids and readies drop to 0 in the same cycle.
  - After release, S1 request 0x3000 completes normally.
- Error response: RRESP=2'b10 on beat 2 of an S0 burst.
  - S0_RRESP=2'b10 on that beat.
  - Burst completes; FSM returns to IDLE.
